// File: rtl/cnn_layer_sequencer.sv
// Sequences a chain of layer engines, then serially picks the highest signed class score.
// Optional per-layer watchdog enabled by defining CNN_SEQ_WATCHDOG_EN.
module cnn_layer_sequencer #(
  parameter int NUM_LAYERS     = 4,
  parameter int NUM_CLASSES    = 5,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 65535,
  localparam int CLS_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1,
  localparam int LYR_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          main_start,
  input  logic                          cont_mode,
  input  logic [NUM_LAYERS-1:0]         layer_done,
  input  logic [NUM_CLASSES*DATA_W-1:0] scores,
  output logic [NUM_LAYERS-1:0]         layer_start,
  output logic                          busy,
  output logic                          result_valid,
  output logic [CLS_W-1:0]              class_idx,
  output logic [7:0]                    seg_final,
  output logic                          err,
  output logic [LYR_W-1:0]              err_layer
);

  if (NUM_LAYERS < 1 || NUM_LAYERS > 16 || NUM_CLASSES < 2 || NUM_CLASSES > 10 ||
      DATA_W < 1 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 1048575) begin : g_param_check
    $error("cnn_layer_sequencer: parameter out of range");
  end

  typedef enum logic [2:0] {
    IDLE, START, WAIT, ARGMAX, DONE
`ifdef CNN_SEQ_WATCHDOG_EN
    , ERR
`endif
  } state_t;

  localparam logic [NUM_LAYERS-1:0] ONE      = NUM_LAYERS'(1);
  localparam logic [LYR_W-1:0]      LAST_LYR = LYR_W'(NUM_LAYERS - 1);
  localparam logic [CLS_W-1:0]      LAST_CLS = CLS_W'(NUM_CLASSES - 1);

  state_t                          state;
  logic [LYR_W-1:0]                lyr;
  logic [CLS_W-1:0]                scan;
  logic [CLS_W-1:0]                best_idx;
  logic signed [DATA_W-1:0]        max_val;
  logic [NUM_CLASSES*DATA_W-1:0]   score_reg;
  logic signed [DATA_W-1:0]        cur_score;
  logic                            take;
  logic [CLS_W-1:0]                cand_idx;

`ifdef CNN_SEQ_WATCHDOG_EN
  localparam int WD_W = 20;
  logic [WD_W-1:0] wd;
`else
  assign err       = 1'b0;
  assign err_layer = '0;
`endif

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 8'hC0;
      4'd1:    seg_code = 8'hF9;
      4'd2:    seg_code = 8'hA4;
      4'd3:    seg_code = 8'hB0;
      4'd4:    seg_code = 8'h99;
      4'd5:    seg_code = 8'h92;
      4'd6:    seg_code = 8'h82;
      4'd7:    seg_code = 8'hF8;
      4'd8:    seg_code = 8'h80;
      4'd9:    seg_code = 8'h90;
      default: seg_code = 8'hFF;
    endcase
  endfunction

  // Class 0 always seeds the running max; later classes win only when strictly greater.
  always_comb begin
    cur_score = score_reg[scan*DATA_W +: DATA_W];
    take      = (scan == '0) || (cur_score > max_val);
    cand_idx  = take ? scan : best_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      lyr          <= '0;
      scan         <= '0;
      best_idx     <= '0;
      max_val      <= '0;
      score_reg    <= '0;
      layer_start  <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      class_idx    <= '0;
      seg_final    <= 8'hFF;
`ifdef CNN_SEQ_WATCHDOG_EN
      wd           <= '0;
      err          <= 1'b0;
      err_layer    <= '0;
`endif
    end else begin
      layer_start  <= '0;
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (main_start) begin
            lyr         <= '0;
            layer_start <= ONE;
            busy        <= 1'b1;
            state       <= START;
          end
        end
        START: begin
          state <= WAIT;
`ifdef CNN_SEQ_WATCHDOG_EN
          wd    <= '0;
`endif
        end
        WAIT: begin
          if (layer_done[lyr]) begin
            if (lyr == LAST_LYR) begin
              score_reg <= scores;
              scan      <= '0;
              state     <= ARGMAX;
            end else begin
              lyr         <= lyr + 1'b1;
              layer_start <= ONE << (lyr + 1'b1);
              state       <= START;
            end
          end
`ifdef CNN_SEQ_WATCHDOG_EN
          else if (wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
            err       <= 1'b1;
            err_layer <= lyr;
            seg_final <= 8'h86;
            busy      <= 1'b0;
            state     <= ERR;
          end else begin
            wd <= wd + 1'b1;
          end
`endif
        end
        ARGMAX: begin
          if (take) begin
            max_val  <= cur_score;
            best_idx <= scan;
          end
          // The final compare feeds the outputs directly so DONE presents the result.
          if (scan == LAST_CLS) begin
            class_idx    <= cand_idx;
            seg_final    <= seg_code(4'(cand_idx));
            result_valid <= 1'b1;
            state        <= DONE;
          end else begin
            scan <= scan + 1'b1;
          end
        end
        DONE: begin
          if (cont_mode) begin
            lyr         <= '0;
            layer_start <= ONE;
            state       <= START;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
`ifdef CNN_SEQ_WATCHDOG_EN
        ERR: begin
          if (main_start) begin
            err         <= 1'b0;
            lyr         <= '0;
            layer_start <= ONE;
            busy        <= 1'b1;
            state       <= START;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Scoreboard bench for cnn_layer_sequencer: queued expected start pulses and results,
// checked by an independent monitor; layer engines modelled by a fixed-latency responder.
module tb_cnn_layer_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        main_start = 1'b0;
  logic        cont_mode = 1'b0;
  logic [3:0]  layer_done;
  logic [3:0]  resp_done = '0;
  logic [3:0]  spur_done = '0;
  logic [39:0] scores = '0;
  logic [3:0]  layer_start;
  logic        busy, result_valid, err;
  logic [2:0]  class_idx;
  logic [7:0]  seg_final;
  logic [1:0]  err_layer;

  assign layer_done = resp_done | spur_done;

  cnn_layer_sequencer #(
    .NUM_LAYERS(4),
    .NUM_CLASSES(5),
    .DATA_W(8),
    .TIMEOUT_CYCLES(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .main_start(main_start),
    .cont_mode(cont_mode),
    .layer_done(layer_done),
    .scores(scores),
    .layer_start(layer_start),
    .busy(busy),
    .result_valid(result_valid),
    .class_idx(class_idx),
    .seg_final(seg_final),
    .err(err),
    .err_layer(err_layer)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_done3 = 0;
  logic [3:0] resp_en = 4'hF;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [2:0] cls;
    logic [7:0] seg;
  } res_t;

  res_t exp_res[$];
  int   exp_start[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Layer engines: done pulses 3 cycles after each start seen.
  initial begin
    int cnt[4];
    foreach (cnt[k]) cnt[k] = 0;
    forever begin
      @(negedge clk);
      resp_done = '0;
      if (rst) begin
        foreach (cnt[k]) cnt[k] = 0;
      end else begin
        for (int k = 0; k < 4; k++) begin
          if (cnt[k] > 0) begin
            cnt[k]--;
            if (cnt[k] == 0) begin
              resp_done[k] = 1'b1;
              if (k == 3) last_done3 = cyc;
            end
          end
        end
        for (int k = 0; k < 4; k++)
          if (layer_start[k] && resp_en[k]) cnt[k] = 3;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT emits a start pulse or a result.
  initial begin
    logic [3:0] prev_start;
    int k;
    res_t r;
    prev_start = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_start = '0;
      end else begin
        if (layer_start != '0) begin
          if (exp_start.size() == 0) check("unexpected_start", 32'(layer_start), 0);
          else begin
            k = exp_start.pop_front();
            check("start_onehot", 32'(layer_start), 32'(1) << k);
          end
          check("start_single_cycle", 32'(prev_start), 0);
        end
        if (result_valid) begin
          if (exp_res.size() == 0) check("unexpected_result", 32'(result_valid), 0);
          else begin
            r = exp_res.pop_front();
            check("class_idx", 32'(class_idx), 32'(r.cls));
            check("seg_final", 32'(seg_final), 32'(r.seg));
            check("argmax_latency", 32'(cyc - last_done3), 6);
          end
        end
        prev_start = layer_start;
      end
    end
  end

  function automatic logic [39:0] pk(input int a0, a1, a2, a3, a4);
    return {8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  task automatic push_run(input logic [2:0] c, input logic [7:0] s);
    res_t r;
    for (int k = 0; k < 4; k++) exp_start.push_back(k);
    r.cls = c;
    r.seg = s;
    exp_res.push_back(r);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    main_start = 1'b1;
    @(negedge clk);
    main_start = 1'b0;
  endtask

  task automatic wait_result(input string name);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (result_valid) return;
    end
    check({name, "_timeout"}, 32'(result_valid), 1);
  endtask

  task automatic wait_start(input int k, input string name);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (layer_start[k]) return;
    end
    check({name, "_timeout"}, 32'(layer_start[k]), 1);
  endtask

  logic [39:0] vec_s[5];
  logic [2:0]  vec_c[5];
  logic [7:0]  vec_g[5];

  initial begin
    vec_s[0] = pk(10, -3, 25, 25, 7);              vec_c[0] = 3'd2; vec_g[0] = 8'hA4;
    vec_s[1] = pk(-128, -128, -128, -128, -128);   vec_c[1] = 3'd0; vec_g[1] = 8'hC0;
    vec_s[2] = pk(-5, -1, -7, -1, -100);           vec_c[2] = 3'd1; vec_g[2] = 8'hF9;
    vec_s[3] = pk(0, 0, 0, 0, 127);                vec_c[3] = 3'd4; vec_g[3] = 8'h99;
    vec_s[4] = pk(-128, -128, -128, 127, -128);    vec_c[4] = 3'd3; vec_g[4] = 8'hB0;

    repeat (3) @(negedge clk);
    check("rst_layer_start", 32'(layer_start), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_result_valid", 32'(result_valid), 0);
    check("rst_class_idx", 32'(class_idx), 0);
    check("rst_seg_final", 32'(seg_final), 32'h FF);
    check("rst_err", 32'(err), 0);
    check("rst_err_layer", 32'(err_layer), 0);
    rst = 1'b0;

    // Directed score vectors, one full run each.
    for (int i = 0; i < 5; i++) begin
      scores = vec_s[i];
      push_run(vec_c[i], vec_g[i]);
      pulse_start();
      wait_result("run");
      @(negedge clk);
      check("idle_after_done", 32'(busy), 0);
      check("class_hold", 32'(class_idx), 32'(vec_c[i]));
    end

    // A done on a layer other than the active one must not advance the chain.
    scores = vec_s[2];
    push_run(vec_c[2], vec_g[2]);
    pulse_start();
    wait_start(1, "spur_wait_start1");
    @(negedge clk);
    spur_done = 4'b1000;
    @(negedge clk);
    check("spur_no_start", 32'(layer_start), 0);
    @(negedge clk);
    spur_done = '0;
    check("spur_no_start_late", 32'(layer_start), 0);
    wait_result("spur_run");

    // Continuous mode: three back-to-back runs, stray main_start pulses ignored.
    cont_mode = 1'b1;
    scores = vec_s[0];
    for (int i = 0; i < 3; i++) push_run(vec_c[0], vec_g[0]);
    pulse_start();
    repeat (4) @(negedge clk);
    main_start = 1'b1;
    @(negedge clk);
    main_start = 1'b0;
    wait_result("cont_run1");
    @(negedge clk);
    check("cont_restart1", 32'(layer_start), 1);
    repeat (6) @(negedge clk);
    main_start = 1'b1;
    @(negedge clk);
    main_start = 1'b0;
    wait_result("cont_run2");
    @(negedge clk);
    check("cont_restart2", 32'(layer_start), 1);
    wait_result("cont_run3");
    cont_mode = 1'b0;
    @(negedge clk);
    check("cont_stop_no_start", 32'(layer_start), 0);
    check("cont_stop_busy", 32'(busy), 0);

    // Reset during ARGMAX: outputs clear immediately and no result appears.
    scores = vec_s[4];
    for (int k = 0; k < 4; k++) exp_start.push_back(k);
    pulse_start();
    for (int i = 0; i < 300 && !layer_done[3]; i++) @(negedge clk);
    check("argrst_done3_seen", 32'(layer_done[3]), 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("argrst_busy", 32'(busy), 0);
    check("argrst_class_idx", 32'(class_idx), 0);
    check("argrst_seg_final", 32'(seg_final), 32'h FF);
    check("argrst_result_valid", 32'(result_valid), 0);
    check("argrst_layer_start", 32'(layer_start), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("argrst_stays_idle", 32'(busy), 0);

    scores = vec_s[3];
    push_run(vec_c[3], vec_g[3]);
    pulse_start();
    wait_result("after_rst_run");

`ifdef CNN_SEQ_WATCHDOG_EN
    // Layer 2 never completes: watchdog fires after 20 WAIT cycles.
    resp_en = 4'b1011;
    for (int k = 0; k < 3; k++) exp_start.push_back(k);
    pulse_start();
    wait_start(2, "wd_wait_start2");
    repeat (20) @(negedge clk);
    check("wd_err_not_yet", 32'(err), 0);
    check("wd_busy_waiting", 32'(busy), 1);
    @(negedge clk);
    check("wd_err", 32'(err), 1);
    check("wd_err_layer", 32'(err_layer), 2);
    check("wd_seg_e", 32'(seg_final), 32'h 86);
    check("wd_busy", 32'(busy), 0);
    resp_en = 4'hF;
    scores = vec_s[0];
    push_run(vec_c[0], vec_g[0]);
    pulse_start();
    check("wd_err_cleared", 32'(err), 0);
    check("wd_restart_busy", 32'(busy), 1);
    wait_result("wd_recover_run");
`endif

    repeat (5) @(negedge clk);
    check("start_queue_empty", 32'(exp_start.size()), 0);
    check("result_queue_empty", 32'(exp_res.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL global_timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
